// File: rtl/if_id_queue.sv
// IF->ID instruction queue: show-ahead FIFO of {PC, instruction} pairs.
// Lets fetch run ahead of decode stalls; flush drops wrong-path entries.
module if_id_queue #(
    parameter int WORD_LEN = 32,
    parameter int DEPTH    = 4,
    parameter int PTR_W    = 2
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                flush,
    input  logic                in_valid,
    input  logic [WORD_LEN-1:0] in_pc,
    input  logic [WORD_LEN-1:0] in_instr,
    output logic                in_ready,
    output logic                out_valid,
    input  logic                out_ready,
    output logic [WORD_LEN-1:0] out_pc,
    output logic [WORD_LEN-1:0] out_instr,
    output logic [PTR_W:0]      count
);

    localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);

    logic [WORD_LEN-1:0] pc_mem    [DEPTH];
    logic [WORD_LEN-1:0] instr_mem [DEPTH];

    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [PTR_W:0]   count_q, count_d;

    logic push;
    logic pop;

    assign in_ready  = (count_q != FULL);
    assign out_valid = (count_q != '0);
    assign count     = count_q;

    assign push = in_valid & in_ready;
    assign pop  = out_valid & out_ready;

    // Empty queue shows all-zero words so ID decodes a NOP bubble.
    assign out_pc    = out_valid ? pc_mem[rd_ptr_q]    : '0;
    assign out_instr = out_valid ? instr_mem[rd_ptr_q] : '0;

    // Pointer and occupancy next-state; flush overrides push and pop.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (flush) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            count_d  = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
            if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
            unique case ({push, pop})
                2'b10:   count_d = count_q + (PTR_W+1)'(1);
                2'b01:   count_d = count_q - (PTR_W+1)'(1);
                default: count_d = count_q;
            endcase
        end
    end

    // Control state registers, cleared asynchronously.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    // Payload storage; contents are don't-care until written.
    always_ff @(posedge clk) begin
        if (push && !flush) begin
            pc_mem[wr_ptr_q]    <= in_pc;
            instr_mem[wr_ptr_q] <= in_instr;
        end
    end

endmodule
